// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and sequencer for the iterative 32-cycle divider (DIV/DIVU/MTHI/MTLO).
// Optional build macro DIV_ZERO_BYPASS_EN: divide-by-zero resolves locally without launching the divider.
module hilo_div_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 40,
   parameter int unsigned CNT_W          = 6
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        op_valid_i,
   input  logic [2:0]  op_code_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic        op_ready_o,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_err_o,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   output logic        div_signed_o,
   output logic        div_start_o,
   input  logic        div_busy_i,
   input  logic [31:0] div_q_i,
   input  logic [31:0] div_r_i
);

   // state  | meaning
   // IDLE   | accepting ops; MTHI/MTLO write here
   // LAUNCH | start pulse to divider (held off while divider still busy)
   // WAIT   | counting divider cycles, watching busy rise then fall
   // DONE   | capture quotient/remainder into LO/HI
   // ZBYP   | divide-by-zero resolved locally (bypass build only)
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ZBYP   = 3'd4;

   localparam logic [2:0] OP_DIV  = 3'b001;
   localparam logic [2:0] OP_DIVU = 3'b010;
   localparam logic [2:0] OP_MTHI = 3'b011;
   localparam logic [2:0] OP_MTLO = 3'b100;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             err_q, err_d;
   logic [31:0]      dvd_q, dvd_d;
   logic [31:0]      dvs_q, dvs_d;
   logic             sgn_q, sgn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic             div_req;

   assign div_req = op_valid_i && ((op_code_i == OP_DIV) || (op_code_i == OP_DIVU));

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      err_d   = err_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid_i) begin
               case (op_code_i)
                  OP_DIV, OP_DIVU: begin
                     dvd_d  = op_a_i;
                     dvs_d  = op_b_i;
                     sgn_d  = (op_code_i == OP_DIV);
                     cnt_d  = '0;
                     seen_d = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                     state_d = (op_b_i == 32'd0) ? S_ZBYP : S_LAUNCH;
`else
                     state_d = S_LAUNCH;
`endif
                  end
                  OP_MTHI: hi_d = op_a_i;
                  OP_MTLO: lo_d = op_a_i;
                  default: ;
               endcase
            end
         end
         S_LAUNCH: begin
            // A divider left busy by an earlier timeout must not see a second start.
            if (!div_busy_i) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (div_busy_i) begin
               seen_d = 1'b1;
            end
            if (seen_q && !div_busy_i) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            hi_d    = div_r_i;
            lo_d    = div_q_i;
            state_d = S_IDLE;
         end
`ifdef DIV_ZERO_BYPASS_EN
         S_ZBYP: begin
            hi_d    = dvd_q;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         err_q   <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         err_q   <= err_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
      end
   end

   assign op_ready_o     = (state_q == S_IDLE);
   assign stall_o        = (state_q != S_IDLE) || div_req;
   assign hi_o           = hi_q;
   assign lo_o           = lo_q;
   assign div_err_o      = err_q;
   assign div_dividend_o = dvd_q;
   assign div_divisor_o  = dvs_q;
   assign div_signed_o   = sgn_q;
   assign div_start_o    = (state_q == S_LAUNCH) && !div_busy_i;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: stub 32-cycle divider, transaction-level timeline model, per-cycle compare.
module tb_hilo_div_ctrl;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        op_valid_i;
   logic [2:0]  op_code_i;
   logic [31:0] op_a_i, op_b_i;
   logic        op_ready_o, stall_o, div_err_o, div_signed_o, div_start_o;
   logic [31:0] hi_o, lo_o, div_dividend_o, div_divisor_o;
   logic        div_busy_i;
   logic [31:0] div_q_i, div_r_i;

   hilo_div_ctrl dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .op_valid_i(op_valid_i), .op_code_i(op_code_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
      .op_ready_o(op_ready_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
      .div_err_o(div_err_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
      .div_signed_o(div_signed_o), .div_start_o(div_start_o),
      .div_busy_i(div_busy_i), .div_q_i(div_q_i), .div_r_i(div_r_i)
   );

   always #5 clock_i = ~clock_i;

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 1'b0;
   bit stub_stuck = 1'b0;
   int stub_cnt;
   int n_starts = 0;
   bit last_start_signed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Divider arithmetic: truncate toward zero, remainder follows dividend; x/0 gives q=all-ones, r=x.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Stub divider: busy for 32 cycles after start, or forever when stuck.
   always @(posedge clock_i) begin
      logic [31:0] q, r;
      if (reset_i) begin
         div_busy_i <= 1'b0;
         stub_cnt   <= 0;
         div_q_i    <= '0;
         div_r_i    <= '0;
      end else if (div_start_o) begin
         ref_div(div_dividend_o, div_divisor_o, div_signed_o, q, r);
         div_busy_i <= 1'b1;
         stub_cnt   <= 32;
         div_q_i    <= q;
         div_r_i    <= r;
      end else if (div_busy_i && !stub_stuck) begin
         if (stub_cnt == 1) div_busy_i <= 1'b0;
         stub_cnt <= stub_cnt - 1;
      end
   end

   // Timeline model: a divide occupies the controller for a fixed number of edges after accept
   // (1 launch + 1 start seen + 32 busy + 1 done = 35, or 1 launch + 40 wait cycles = 41 on timeout).
   int          m_left = 0;
   int          m_el   = 0;
   bit          m_to, m_zb, m_s;
   logic [31:0] m_hi, m_lo, m_a, m_b, m_q, m_r;
   bit          m_err;

   always @(posedge clock_i) begin
      if (reset_i) begin
         m_left = 0; m_el = 0; m_hi = '0; m_lo = '0; m_err = 1'b0; m_zb = 1'b0;
      end else if (m_left == 0) begin
         if (op_valid_i) begin
            case (op_code_i)
               3'd1, 3'd2: begin
                  m_a = op_a_i; m_b = op_b_i; m_s = (op_code_i == 3'd1); m_el = 0;
                  m_zb = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                  if (op_b_i == 32'd0) begin
                     m_zb = 1'b1;
                     m_left = 1;
                  end else
`endif
                  begin
                     m_to = stub_stuck;
                     m_left = m_to ? 41 : 35;
                     ref_div(m_a, m_b, m_s, m_q, m_r);
                  end
               end
               3'd3: m_hi = op_a_i;
               3'd4: m_lo = op_a_i;
               default: ;
            endcase
         end
      end else begin
         m_left--;
         m_el++;
         if (m_left == 0) begin
            if (m_zb) begin
               m_hi = m_a; m_lo = 32'hFFFF_FFFF;
            end else if (m_to) begin
               m_err = 1'b1;
            end else begin
               m_hi = m_r; m_lo = m_q;
            end
         end
      end
   end

   always @(negedge clock_i) begin
      bit exp_start;
      if (check_en) begin
         exp_start = (m_left != 0) && (m_el == 0) && !m_zb;
         chk("op_ready", {31'd0, op_ready_o}, {31'd0, m_left == 0});
         chk("stall", {31'd0, stall_o},
             {31'd0, (m_left != 0) || (op_valid_i && (op_code_i == 3'd1 || op_code_i == 3'd2))});
         chk("hi", hi_o, m_hi);
         chk("lo", lo_o, m_lo);
         chk("div_err", {31'd0, div_err_o}, {31'd0, m_err});
         chk("div_start", {31'd0, div_start_o}, {31'd0, exp_start});
         if (exp_start) begin
            chk("div_dividend", div_dividend_o, m_a);
            chk("div_divisor", div_divisor_o, m_b);
            chk("div_signed", {31'd0, div_signed_o}, {31'd0, m_s});
         end
      end
      if (div_start_o === 1'b1) begin
         n_starts++;
         last_start_signed = div_signed_o;
      end
   end

   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock_i);
         if (op_ready_o) ok = 1'b1;
      end
      @(posedge clock_i); #1;
      op_valid_i = 1'b0; op_code_i = 3'd0;
      if (!ok) bound_fail(name);
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock_i); #1;
      op_valid_i = 1'b1; op_code_i = c; op_a_i = a; op_b_i = b;
      wait_accept("accept");
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 120 && !ok; i++) begin
         @(negedge clock_i);
         if (!stall_o && op_ready_o) ok = 1'b1;
      end
      if (!ok) bound_fail(name);
   endtask

   initial begin
      int s0;
      logic [2:0] c;
      logic [31:0] a, b;
      reset_i = 1'b1; op_valid_i = 1'b0; op_code_i = 3'd0; op_a_i = '0; op_b_i = '0;
      repeat (3) @(posedge clock_i);
      #1 reset_i = 1'b0;
      check_en = 1'b1;
      @(negedge clock_i);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_err", {31'd0, div_err_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);

      s0 = n_starts;
      issue(3'd1, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div_m7_2_idle");
      chk("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
      chk("div_m7_2_starts", n_starts - s0, 32'd1);
      chk("div_m7_2_signed", {31'd0, last_start_signed}, 32'd1);

      s0 = n_starts;
      issue(3'd2, 32'd100, 32'd7);
      wait_idle("divu_100_7_idle");
      chk("divu_100_7_lo", lo_o, 32'd14);
      chk("divu_100_7_hi", hi_o, 32'd2);
      chk("divu_100_7_starts", n_starts - s0, 32'd1);
      chk("divu_100_7_signed", {31'd0, last_start_signed}, 32'd0);

      issue(3'd2, 32'd50, 32'd7);
      @(posedge clock_i); #1;
      op_valid_i = 1'b1; op_code_i = 3'd3; op_a_i = 32'hDEAD_BEEF; op_b_i = '0;
      repeat (5) @(negedge clock_i);
      chk("mthi_busy_ready", {31'd0, op_ready_o}, 32'd0);
      chk("mthi_busy_hi", hi_o, 32'd2);
      wait_accept("mthi_accept");
      @(negedge clock_i);
      chk("mthi_hi", hi_o, 32'hDEAD_BEEF);
      chk("mthi_lo", lo_o, 32'd7);

      issue(3'd1, 32'd1000, 32'd3);
      repeat (11) @(posedge clock_i);
      #1 reset_i = 1'b1;
      @(posedge clock_i); #1 reset_i = 1'b0;
      @(negedge clock_i);
      chk("rstmid_hi", hi_o, 32'd0);
      chk("rstmid_lo", lo_o, 32'd0);
      chk("rstmid_stall", {31'd0, stall_o}, 32'd0);
      repeat (40) @(negedge clock_i);
      chk("rstmid_nowb_lo", lo_o, 32'd0);

      for (int i = 0; i < 30; i++) begin
         c = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 5000));
         if (b == 32'd0) b = 32'd1;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         issue(c, a, b);
         repeat ($urandom_range(0, 3)) @(posedge clock_i);
         wait_idle("rand_idle");
      end

      s0 = n_starts;
      issue(3'd1, 32'd123, 32'd0);
      wait_idle("dz_idle");
      chk("dz_hi", hi_o, 32'd123);
      chk("dz_lo", lo_o, 32'hFFFF_FFFF);
`ifdef DIV_ZERO_BYPASS_EN
      chk("dz_starts", n_starts - s0, 32'd0);
`else
      chk("dz_starts", n_starts - s0, 32'd1);
`endif

      stub_stuck = 1'b1;
      issue(3'd1, 32'd9, 32'd2);
      wait_idle("timeout_idle");
      chk("timeout_err", {31'd0, div_err_o}, 32'd1);
      chk("timeout_stall", {31'd0, stall_o}, 32'd0);
      chk("timeout_hi", hi_o, 32'd123);
      chk("timeout_lo", lo_o, 32'hFFFF_FFFF);
      repeat (3) @(negedge clock_i);
      chk("timeout_err_sticky", {31'd0, div_err_o}, 32'd1);

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
